// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the byte-lane data memory.
package dmem_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} mem_size_e;
    typedef enum logic {INIT, RUN} dmem_state_e;

    function automatic logic [3:0] byte_en(mem_size_e size, logic [1:0] off);
        return size == SZ_B ? 4'b0001 << off :
               size == SZ_H ? 4'b0011 << off :
               size == SZ_W ? 4'b1111 : 4'b0000;
    endfunction

    // Word loads are always aligned, so the raw word is returned unshifted.
    function automatic logic [31:0] load_ext(mem_size_e size, logic [1:0] off, logic uns, logic [31:0] word);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        return size == SZ_B ? {{24{~uns & s[7]}}, s[7:0]} :
               size == SZ_H ? {{16{~uns & s[15]}}, s[15:0]} :
               size == SZ_W ? word : 32'h0;
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte enables, store lane shift, load extraction and alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata,
    output logic        misalign
);
    mem_size_e sz;

    always_comb begin
        sz       = mem_size_e'(size);
        be       = byte_en(sz, offset);
        wdata_sh = wdata << {offset, 3'b000};
        rdata    = load_ext(sz, offset, is_unsigned, raw);
        misalign = (sz == SZ_H && offset[0]) || (sz == SZ_W && offset != 2'd0) || sz == SZ_ILL;
    end
endmodule

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: byte-addressable data memory with sized loads/stores,
// error reporting, one-cycle registered response and a post-reset clear sweep.
module data_memory_bytelane
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = 7,
    parameter int          DEPTH_WORDS = 32,
    parameter int          INIT_CLEAR  = 1,
    parameter logic [31:0] RESET_RDATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int IDX_W = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]       mem [DEPTH_WORDS];
    dmem_state_e       state, state_nx;
    logic [IDX_W-1:0]  cnt, ridx;
    logic [ADDR_W-3:0] idx;
    logic [3:0]        be;
    logic [31:0]       wdata_sh, ld;
    logic              misalign, err, accept, wr;

    assign idx    = req_addr[ADDR_W-1:2];
    assign ridx   = idx[IDX_W-1:0];
    assign accept = req_valid && req_ready;
    assign err    = misalign || 32'(idx) >= 32'(DEPTH_WORDS);
    assign wr     = accept && req_we && !err;

    dmem_lane_align u_align (
        .size        (req_size),
        .offset      (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .raw         (mem[ridx]),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata       (ld),
        .misalign    (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state == INIT && (INIT_CLEAR == 0 || cnt == LAST) ? RUN : state;
    end

    always_comb begin
        req_ready = state == RUN;
        init_done = state == RUN;
    end

    // Storage is never reset; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT && INIT_CLEAR != 0) mem[cnt] <= '0;
            else if (wr)
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[ridx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= RESET_RDATA;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && err;
            if (accept) rsp_rdata <= err || req_we ? 32'h0 : ld;
        end
    end
endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: directed checks of init sweep, sized access and errors.
module tb_data_memory_bytelane;
    logic        clk = 0, rst = 1, req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [7:0]  req_addr = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, rsp_valid, rsp_err, init_done;
    logic [31:0] rsp_rdata;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    data_memory_bytelane #(.ADDR_W(8), .DEPTH_WORDS(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic op(input string tag, input logic we, input logic [7:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_unsigned = u; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    endtask

    task automatic count_init(input string tag);
        int n = 0;
        int seen = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        req_valid = 0;
        chk({tag, "_cycles"}, 32'(n), 32'd32);
        chk({tag, "_no_rsp"}, 32'(seen), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'hDEADBEEF);
        rst = 0;
        count_init("init1");
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        rst = 0;
        req_valid = 1; req_we = 1; req_addr = 8'h00; req_size = 2'd2; req_wdata = 32'hFFFFFFFF;
        count_init("init2");
        for (int w = 0; w < 32; w++) op("zero", 0, 8'(w * 4), 2'd2, 0, 0, 32'h0, 0);
        op("sw08", 1, 8'h08, 2'd2, 0, 32'h12345678, 32'h0, 0);
        op("lw08", 0, 8'h08, 2'd2, 0, 0, 32'h12345678, 0);
        op("sw10", 1, 8'h10, 2'd2, 0, 32'h0, 32'h0, 0);
        op("sb11", 1, 8'h11, 2'd0, 0, 32'h80, 32'h0, 0);
        op("lb11", 0, 8'h11, 2'd0, 0, 0, 32'hFFFFFF80, 0);
        op("lbu11", 0, 8'h11, 2'd0, 1, 0, 32'h00000080, 0);
        op("lw10", 0, 8'h10, 2'd2, 0, 0, 32'h00008000, 0);
        op("sh16", 1, 8'h16, 2'd1, 0, 32'h0000BEEF, 32'h0, 0);
        op("lh16", 0, 8'h16, 2'd1, 0, 0, 32'hFFFFBEEF, 0);
        op("lhu16", 0, 8'h16, 2'd1, 1, 0, 32'h0000BEEF, 0);
        op("lw14", 0, 8'h14, 2'd2, 0, 0, 32'hBEEF0000, 0);
        op("lb17", 0, 8'h17, 2'd0, 0, 0, 32'hFFFFFFBE, 0);
        op("lw02a", 0, 8'h02, 2'd2, 0, 0, 32'h0, 1);
        op("lw02b", 0, 8'h02, 2'd2, 0, 0, 32'h0, 1);
        op("sh03", 1, 8'h03, 2'd1, 0, 32'h0000AAAA, 32'h0, 1);
        op("lw00a", 0, 8'h00, 2'd2, 0, 0, 32'h0, 0);
        op("size11", 0, 8'h08, 2'd3, 0, 0, 32'h0, 1);
        op("sz11st", 1, 8'h00, 2'd3, 0, 32'h55555555, 32'h0, 1);
        op("lw80", 0, 8'h80, 2'd2, 0, 0, 32'h0, 1);
        op("sw80", 1, 8'h80, 2'd2, 0, 32'hCAFEF00D, 32'h0, 1);
        op("lw00b", 0, 8'h00, 2'd2, 0, 0, 32'h0, 0);
        op("lw08b", 0, 8'h08, 2'd2, 0, 0, 32'h12345678, 0);
        @(posedge clk); #1;
        chk("idle_valid", 32'(rsp_valid), 32'd0);
        chk("idle_hold", rsp_rdata, 32'h12345678);
        op("lhu_last", 0, 8'h14, 2'd1, 1, 0, 32'h00000000, 0);
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 8'h08; req_size = 2'd2;
        rst = 1;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 0;
        chk("drop_valid", 32'(rsp_valid), 32'd0);
        chk("drop_rdata", rsp_rdata, 32'hDEADBEEF);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_memory_bytelane.md
Name: data_memory_bytelane

Overview:
- Parametrised, byte-addressable data memory for the core's MEM stage. Successor to the 32-word word-only data memory.
- Adds RISC-V load/store sizing (LB/LBU/LH/LHU/LW, SB/SH/SW) with per-byte write enables and load sign/zero extension.
- Adds misalignment and range error reporting, a valid/ready request port, and a registered one-cycle response.
- Adds a post-reset clear sweep, so software never reads X.

Parameters:
- ADDR_W, 7, byte-address width. Must be ≥ 3.
- DEPTH_WORDS, 32, number of 32-bit words. Must satisfy DEPTH_WORDS ≤ 2**(ADDR_W-2).
- INIT_CLEAR, 1, when 1, zero every word after reset before accepting requests.
- RESET_RDATA, 32'hDEADBEEF, value of rsp_rdata while in reset.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_wdata  in  32  store data, LSB-justified.
- rsp_valid  out  1  one-cycle pulse, response for the accepted request.
- rsp_rdata  out  32  extended load data. 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: request was misaligned, illegal size or out of range.
- init_done  out  1  clear sweep complete. Stays high until next rst.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: req_ready 0, rsp_valid 0, rsp_err 0, init_done 0, rsp_rdata RESET_RDATA, FSM = INIT, sweep counter 0. Memory contents are not reset directly.
- FSM states INIT and RUN.
  - INIT: each cycle write 32'h0 to word[cnt], then cnt++.
  - When cnt == DEPTH_WORDS-1 is written, go to RUN next cycle.
  - Sweep takes exactly DEPTH_WORDS cycles after rst deasserts.
  - If INIT_CLEAR == 0, go to RUN on the first cycle after rst deasserts.
- RUN: req_ready = 1 and init_done = 1. The block never back-pressures in RUN.
- rst asserted at any time, including mid-sweep: return to INIT with cnt = 0. Any pending response is dropped (rsp_valid 0 next cycle).
- Accept condition: req_valid && req_ready. req_valid while not ready is ignored; no response.
- Error checks, on word index = req_addr[ADDR_W-1:2] and byte offset = req_addr[1:0]:
  - half with offset[0] = 1;
  - word with offset != 0;
  - req_size == 11;
  - word index ≥ DEPTH_WORDS.
  - On error: no memory write; response is rsp_err = 1, rsp_rdata = 0.
- Store: byte enables derived from size and offset.
  - SB: 1 lane at offset.
  - SH: lanes offset and offset+1.
  - SW: all 4 lanes.
  - Data is lane-shifted by 8*offset. Memory updates at the accepting edge.
- Load: memory read at the accepting edge. Result is extracted by size/offset and extended per req_unsigned; req_unsigned is ignored for word.
- Latency: response (rsp_valid = 1) appears exactly one cycle after acceptance. Stores also respond, with rsp_rdata = 0.
- Throughput: one request per cycle.
- Back-to-back ordering: a load accepted in cycle N+1 sees the store accepted in cycle N, including partial-lane merges. Untouched lanes keep their old value.
- rsp_rdata holds its last value when rsp_valid = 0.

Decomposition:
- dmem_pkg:
  - enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_ILL};
  - enum dmem_state_e {INIT, RUN};
  - function for byte-enable generation;
  - function for load extraction/extension.
- One natural sub-module: dmem_lane_align.
  - Combinational.
  - Inputs: size, offset, unsigned, wdata, raw word.
  - Outputs: be[3:0], shifted wdata, extended load data, misalign flag.
- Top module holds the FSM, the storage array and the response registers.

Test Plan:
- Reset/init, defaults: hold rst 3 cycles, release → req_ready 0 for exactly 32 cycles. Then init_done = 1. A load from every word returns 0 with rsp_err 0.
- Reset mid-init: assert rst at sweep cycle 10 → counter restarts. req_ready stays 0 for 32 full cycles after release.
- Word store/load: SW 0x12345678 @0x08, then LW @0x08 → rsp_rdata 0x12345678 one cycle after the load's acceptance.
- Byte merge and extension: SW 0x00000000 @0x10, then SB 0x80 @0x11, then LB @0x11 → 0xFFFFFF80. Then LBU @0x11 → 0x00000080. Then LW @0x10 → 0x00008000.
- Half store/load: SH 0xBEEF @0x16, then LH @0x16 → 0xFFFFBEEF. Then LHU → 0x0000BEEF.
- Errors, each giving rsp_err 1 and rsp_rdata 0:
  - LW @0x02, then LW @0x02 again: second load must not see a write.
  - SH 0xAAAA @0x03: word 0 unchanged.
  - size 11.
  - LW @0x80 with ADDR_W = 8, DEPTH_WORDS = 32 (index 32, out of range).
